sr_rw_control: RTL and testbench
================================

SR_RW_CONTROL -- requirements
Module: sr_rw_control

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 170: shift-register length in bits.
REQ-002 SHALL have parameter CNT_WIDTH, default 8: bit-counter width; must satisfy 2^CNT_WIDTH > DATA_WIDTH.
REQ-003 SHALL have parameter SHIFT_DIRECTION, default 1: 1 = MSB out first, 0 = LSB out first.
REQ-004 SHALL have parameter CLK_DIV, default 2: clk cycles per sr_clk half-period; must be >= 1.
REQ-005 SHALL have parameter LOAD_WIDTH, default 1: load_sr pulse length in clk cycles; must be >= 1.
REQ-006 SHALL have port clk, input, 1: single clock; all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port start, input, 1: request a write/readback transaction.
REQ-009 SHALL have port din, input, DATA_WIDTH: word to shift out.
REQ-010 SHALL have port sr_miso, input, 1: serial readback from the shift-register tail.
REQ-011 SHALL have port sr_clk, output, 1: shift-register clock.
REQ-012 SHALL have port sr_data, output, 1: serial data to the shift register.
REQ-013 SHALL have port load_sr, output, 1: latch-enable pulse to the shift register.
REQ-014 SHALL have port busy, output, 1: transaction in progress.
REQ-015 SHALL have port done, output, 1: one-cycle completion pulse.
REQ-016 SHALL have port dout, output, DATA_WIDTH: word captured from sr_miso.

Function
REQ-017 SHALL implement states IDLE, SHIFT, LOAD and DONE; every output SHALL be registered.
REQ-018 IDLE: start=1 at edge T SHALL latch din into a shadow register and enter SHIFT; din changes after T SHALL have no effect.
REQ-019 start while busy=1 or done=1 SHALL be ignored, with no queuing.
REQ-020 SHIFT: with N=DATA_WIDTH and D=CLK_DIV, bit k (k = 0..N-1) SHALL occupy cycles T+1+2kD .. T+2(k+1)D.
REQ-021 During each bit, sr_data SHALL be stable: shadow[N-1-k] if SHIFT_DIRECTION=1, else shadow[k].
REQ-022 During each bit, sr_clk SHALL be low for the first D cycles and high for the last D cycles.
REQ-023 sr_miso SHALL be sampled at the edge where sr_clk rises, once per bit.
REQ-024 The first sampled bit SHALL map to dout[N-1] if SHIFT_DIRECTION=1, else to dout[0].
REQ-025 After bit N-1, LOAD SHALL hold load_sr=1 for cycles T+1+2ND .. T+2ND+LOAD_WIDTH, with sr_clk=0 and sr_data=0.
REQ-026 DONE SHALL occupy the single cycle T+1+2ND+LOAD_WIDTH, with done=1, busy=0 and dout updated with the captured word; the next edge returns to IDLE.
REQ-027 busy SHALL be 1 exactly from T+1 through T+2ND+LOAD_WIDTH.
REQ-028 dout SHALL change only on entry to DONE and hold until the next DONE.
REQ-029 Outside SHIFT, sr_clk=0 and sr_data=0; outside LOAD, load_sr=0.
REQ-030 With CLK_DIV=1, sr_clk SHALL toggle every clk cycle and no bit SHALL be dropped.
REQ-031 The bit counter SHALL count 0..N-1 and clear on leaving SHIFT; it SHALL not wrap.

Reset
REQ-032 While rst=1, on each edge: state=IDLE; sr_clk, sr_data, load_sr, busy and done = 0; dout = 0; all counters cleared.
REQ-033 rst asserted mid-transaction SHALL abort it at the next edge, with no done pulse and dout unchanged from 0.
REQ-034 rst=1 together with start=1 SHALL give reset priority; start is ignored.

Verification
REQ-035 N=8, D=2, LW=3, din=8'hA5, dir=1, sr_miso looped to sr_data -> sr_data sequence 1,0,1,0,0,1,0,1; 8 sr_clk rises; load_sr high 3 cycles at T+33..T+35; done at T+36; dout=8'hA5.
REQ-036 Same settings, dir=0, din=8'h01 -> first bit is 1, then seven 0s; dout=8'h01 with the loopback.
REQ-037 D=1, N=4, din=4'hC, sr_miso tied 1 -> sr_clk toggles every cycle; done at T+9+LW; dout=4'hF.
REQ-038 Pulse start again at T+5 and change din at T+3 -> no effect; output stream unchanged; exactly one done.
REQ-039 Assert rst for one cycle at T+10 -> all outputs 0 on the next cycle; no done; a new start then completes normally.
REQ-040 Hold start=1 continuously -> back-to-back transactions, each starting on the cycle after done, with identical timing.

Source files
------------

// File: rtl/sr_rw_control.sv
`default_nettype none
// ============================================================================
//  Module      : sr_rw_control
//  Description : Serial shift-register writer with simultaneous readback.
//                Shifts a latched word out on sr_data/sr_clk, samples
//                sr_miso on every sr_clk rising edge, pulses load_sr, then
//                reports completion with a one-cycle done pulse and the
//                captured word on dout.
//  Revision    : 1.0 - initial release
// ============================================================================
module sr_rw_control #(
    parameter int DATA_WIDTH      = 170,
    parameter int CNT_WIDTH       = 8,
    parameter int SHIFT_DIRECTION = 1,
    parameter int CLK_DIV         = 2,
    parameter int LOAD_WIDTH      = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  sr_miso,
    output logic                  sr_clk,
    output logic                  sr_data,
    output logic                  load_sr,
    output logic                  busy,
    output logic                  done,
    output logic [DATA_WIDTH-1:0] dout
);

    // Phase counter spans one full bit period of 2*CLK_DIV clk cycles.
    localparam int c_DIV_W = $clog2(2 * CLK_DIV);
    localparam int c_LD_W  = (LOAD_WIDTH > 1) ? $clog2(LOAD_WIDTH) : 1;

    localparam logic [c_DIV_W-1:0]   c_DIV_RISE  = c_DIV_W'(CLK_DIV - 1);
    localparam logic [c_DIV_W-1:0]   c_DIV_LAST  = c_DIV_W'(2 * CLK_DIV - 1);
    localparam logic [CNT_WIDTH-1:0] c_BIT_LAST  = CNT_WIDTH'(DATA_WIDTH - 1);
    localparam logic [c_LD_W-1:0]    c_LOAD_LAST = c_LD_W'(LOAD_WIDTH - 1);

    localparam logic [1:0] c_S_IDLE  = 2'd0;
    localparam logic [1:0] c_S_SHIFT = 2'd1;
    localparam logic [1:0] c_S_LOAD  = 2'd2;
    localparam logic [1:0] c_S_DONE  = 2'd3;

    logic [1:0]            r_state;
    logic [c_DIV_W-1:0]    r_div;
    logic [CNT_WIDTH-1:0]  r_bit_cnt;
    logic [c_LD_W-1:0]     r_load_cnt;
    // Shadow holds the bits still to be sent, aligned so the next one is
    // always at the outgoing end; it is refilled from din only at start.
    logic [DATA_WIDTH-1:0] r_shadow;
    logic [DATA_WIDTH-1:0] r_cap;

    logic                  w_first_bit;
    logic                  w_next_bit;
    logic [DATA_WIDTH-1:0] w_din_rest;
    logic [DATA_WIDTH-1:0] w_shadow_rest;
    logic [DATA_WIDTH-1:0] w_cap_next;

    // Bit ordering for both the outgoing stream and the captured word.
    generate
        if (SHIFT_DIRECTION != 0) begin : g_msb_first
            assign w_first_bit   = din[DATA_WIDTH-1];
            assign w_din_rest    = din << 1;
            assign w_next_bit    = r_shadow[DATA_WIDTH-1];
            assign w_shadow_rest = r_shadow << 1;
            assign w_cap_next    = (r_cap << 1) | DATA_WIDTH'(sr_miso);
        end else begin : g_lsb_first
            assign w_first_bit   = din[0];
            assign w_din_rest    = din >> 1;
            assign w_next_bit    = r_shadow[0];
            assign w_shadow_rest = r_shadow >> 1;
            assign w_cap_next    = (r_cap >> 1) | (DATA_WIDTH'(sr_miso) << (DATA_WIDTH - 1));
        end
    endgenerate

    // Transaction sequencer: all outputs are registered here.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_S_IDLE;
            r_div      <= '0;
            r_bit_cnt  <= '0;
            r_load_cnt <= '0;
            r_shadow   <= '0;
            r_cap      <= '0;
            sr_clk     <= 1'b0;
            sr_data    <= 1'b0;
            load_sr    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            dout       <= '0;
        end else begin
            case (r_state)
                c_S_IDLE: begin
                    if (start) begin
                        r_shadow  <= w_din_rest;
                        sr_data   <= w_first_bit;
                        sr_clk    <= 1'b0;
                        busy      <= 1'b1;
                        r_div     <= '0;
                        r_bit_cnt <= '0;
                        r_state   <= c_S_SHIFT;
                    end
                end

                c_S_SHIFT: begin
                    if (r_div == c_DIV_LAST) begin
                        r_div  <= '0;
                        sr_clk <= 1'b0;
                        if (r_bit_cnt == c_BIT_LAST) begin
                            r_bit_cnt  <= '0;
                            sr_data    <= 1'b0;
                            load_sr    <= 1'b1;
                            r_load_cnt <= '0;
                            r_state    <= c_S_LOAD;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + CNT_WIDTH'(1);
                            sr_data   <= w_next_bit;
                            r_shadow  <= w_shadow_rest;
                        end
                    end else begin
                        r_div <= r_div + c_DIV_W'(1);
                        // Midpoint of the bit: raise sr_clk and sample the
                        // readback while sr_data is still stable.
                        if (r_div == c_DIV_RISE) begin
                            sr_clk <= 1'b1;
                            r_cap  <= w_cap_next;
                        end
                    end
                end

                c_S_LOAD: begin
                    if (r_load_cnt == c_LOAD_LAST) begin
                        r_load_cnt <= '0;
                        load_sr    <= 1'b0;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        dout       <= r_cap;
                        r_state    <= c_S_DONE;
                    end else begin
                        r_load_cnt <= r_load_cnt + c_LD_W'(1);
                    end
                end

                c_S_DONE: begin
                    done    <= 1'b0;
                    r_state <= c_S_IDLE;
                end

                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sr_rw_control.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sr_rw_control
//  Description : Directed self-checking bench for sr_rw_control. Three
//                instances cover MSB-first, LSB-first and CLK_DIV=1 builds;
//                a selector routes start to one instance at a time.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sr_rw_control;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] din;
    int         sel;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Instance A: N=8, D=2, LW=3, MSB first, loopback
    logic       a_start, a_sclk, a_sdata, a_load, a_busy, a_done;
    logic [7:0] a_dout;
    assign a_start = start && (sel == 0);

    sr_rw_control #(.DATA_WIDTH(8), .CNT_WIDTH(4), .SHIFT_DIRECTION(1),
                    .CLK_DIV(2), .LOAD_WIDTH(3)) u_a (
        .clk(clk), .rst(rst), .start(a_start), .din(din), .sr_miso(a_sdata),
        .sr_clk(a_sclk), .sr_data(a_sdata), .load_sr(a_load), .busy(a_busy),
        .done(a_done), .dout(a_dout)
    );

    // Instance B: N=8, D=2, LW=3, LSB first, loopback
    logic       b_start, b_sclk, b_sdata, b_load, b_busy, b_done;
    logic [7:0] b_dout;
    assign b_start = start && (sel == 1);

    sr_rw_control #(.DATA_WIDTH(8), .CNT_WIDTH(4), .SHIFT_DIRECTION(0),
                    .CLK_DIV(2), .LOAD_WIDTH(3)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .din(din), .sr_miso(b_sdata),
        .sr_clk(b_sclk), .sr_data(b_sdata), .load_sr(b_load), .busy(b_busy),
        .done(b_done), .dout(b_dout)
    );

    // Instance C: N=4, D=1, LW=2, MSB first, readback tied high
    logic       c_start, c_sclk, c_sdata, c_load, c_busy, c_done;
    logic [3:0] c_dout;
    assign c_start = start && (sel == 2);

    sr_rw_control #(.DATA_WIDTH(4), .CNT_WIDTH(3), .SHIFT_DIRECTION(1),
                    .CLK_DIV(1), .LOAD_WIDTH(2)) u_c (
        .clk(clk), .rst(rst), .start(c_start), .din(din[3:0]), .sr_miso(1'b1),
        .sr_clk(c_sclk), .sr_data(c_sdata), .load_sr(c_load), .busy(c_busy),
        .done(c_done), .dout(c_dout)
    );

    // Observed control vector {sr_clk, sr_data, load_sr, busy, done} of the selected instance
    logic [4:0] obs_ctl;
    logic [7:0] obs_dout;
    logic       obs_done;
    always_comb begin
        obs_ctl  = {a_sclk, a_sdata, a_load, a_busy, a_done};
        obs_dout = a_dout;
        if (sel == 1) begin
            obs_ctl  = {b_sclk, b_sdata, b_load, b_busy, b_done};
            obs_dout = b_dout;
        end else if (sel == 2) begin
            obs_ctl  = {c_sclk, c_sdata, c_load, c_busy, c_done};
            obs_dout = {4'h0, c_dout};
        end
    end
    assign obs_done = obs_ctl[0];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected {sr_clk, sr_data, load_sr, busy, done} for cycle T+c
    function automatic logic [4:0] exp_ctl(int c, int n, int d, int lw, int dir, logic [7:0] dval);
        int sh;
        int k;
        int ph;
        int bitpos;
        logic b;
        sh = 2 * n * d;
        if (c >= 1 && c <= sh) begin
            k      = (c - 1) / (2 * d);
            ph     = (c - 1) % (2 * d);
            bitpos = (dir != 0) ? (n - 1 - k) : k;
            b      = dval[bitpos];
            return {(ph >= d), b, 1'b0, 1'b1, 1'b0};
        end else if (c > sh && c <= sh + lw) begin
            return 5'b00110;
        end else if (c == sh + lw + 1) begin
            return 5'b00001;
        end
        return 5'b00000;
    endfunction

    // One transaction on instance s, checked cycle by cycle from T+1 to T+2ND+LW+2.
    // Returns at the sample point of the idle cycle after done.
    task automatic run_txn(input string name, input int s, input int n, input int d,
                           input int lw, input int dir, input logic [7:0] dval,
                           input logic [7:0] exp_dout, input logic [7:0] prev_dout,
                           input bit hold, input bit disturb);
        int         last;
        int         ndone;
        logic [4:0] e;
        logic [7:0] ed;
        last  = 2 * n * d + lw + 2;
        ndone = 0;
        sel   = s;
        din   = dval;
        start = 1'b1;
        tick();
        if (!hold) start = 1'b0;
        for (int c = 1; c <= last; c++) begin
            e  = exp_ctl(c, n, d, lw, dir, dval);
            ed = (c >= last - 1) ? exp_dout : prev_dout;
            checks++;
            if (obs_ctl !== e || obs_dout !== ed) begin
                errors++;
                $display("FAIL %s cycle T+%0d: got clk,data,load,busy,done=%b dout=%h, expected %b dout=%h",
                         name, c, obs_ctl, obs_dout, e, ed);
            end
            if (obs_done) ndone++;
            if (disturb && c == 3) din = ~dval;
            if (disturb && c == 5) start = 1'b1;
            if (disturb && c == 6) start = 1'b0;
            if (c != last) tick();
        end
        checks++;
        if (ndone != 1) begin
            errors++;
            $display("FAIL %s done_count: got %0d, expected 1", name, ndone);
        end
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b1;
        sel   = 0;
        din   = 8'hFF;
        tick();
        tick();
        checks++;
        if ({a_sclk, a_sdata, a_load, a_busy, a_done, a_dout} !== 13'h0) begin
            errors++;
            $display("FAIL reset_a: got %h, expected 0", {a_sclk, a_sdata, a_load, a_busy, a_done, a_dout});
        end
        checks++;
        if ({b_sclk, b_sdata, b_load, b_busy, b_done, b_dout} !== 13'h0) begin
            errors++;
            $display("FAIL reset_b: got %h, expected 0", {b_sclk, b_sdata, b_load, b_busy, b_done, b_dout});
        end
        checks++;
        if ({c_sclk, c_sdata, c_load, c_busy, c_done, c_dout} !== 9'h0) begin
            errors++;
            $display("FAIL reset_c: got %h, expected 0", {c_sclk, c_sdata, c_load, c_busy, c_done, c_dout});
        end
        rst   = 1'b0;
        start = 1'b0;
        tick();
        checks++;
        if (a_busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_start_priority: busy got %b, expected 0", a_busy);
        end
    endtask

    task automatic test_shift_msb();
        run_txn("msb_A5", 0, 8, 2, 3, 1, 8'hA5, 8'hA5, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_shift_lsb();
        run_txn("lsb_01", 1, 8, 2, 3, 0, 8'h01, 8'h01, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_clkdiv1();
        run_txn("div1_C", 2, 4, 1, 2, 1, 8'h0C, 8'h0F, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_ignore_start();
        run_txn("ignore_96", 0, 8, 2, 3, 1, 8'h96, 8'h96, 8'hA5, 1'b0, 1'b1);
    endtask

    task automatic test_reset_abort();
        int nbad;
        sel   = 0;
        din   = 8'h3C;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (9) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if ({a_sclk, a_sdata, a_load, a_busy, a_done, a_dout} !== 13'h0) begin
            errors++;
            $display("FAIL abort_outputs: got %h, expected 0", {a_sclk, a_sdata, a_load, a_busy, a_done, a_dout});
        end
        nbad = 0;
        repeat (6) begin
            tick();
            if (a_done !== 1'b0 || a_busy !== 1'b0 || a_dout !== 8'h00) nbad++;
        end
        checks++;
        if (nbad != 0) begin
            errors++;
            $display("FAIL abort_quiet: got %0d active cycles, expected 0", nbad);
        end
        run_txn("after_abort_C3", 0, 8, 2, 3, 1, 8'hC3, 8'hC3, 8'h00, 1'b0, 1'b0);
    endtask

    task automatic test_back_to_back();
        run_txn("b2b_first_81", 0, 8, 2, 3, 1, 8'h81, 8'h81, 8'hC3, 1'b1, 1'b0);
        run_txn("b2b_second_7E", 0, 8, 2, 3, 1, 8'h7E, 8'h7E, 8'h81, 1'b1, 1'b0);
        start = 1'b0;
        tick();
        checks++;
        if (a_busy !== 1'b0 || a_dout !== 8'h7E) begin
            errors++;
            $display("FAIL b2b_stop: got busy=%b dout=%h, expected busy=0 dout=7e", a_busy, a_dout);
        end
    endtask

    initial begin
        rst   = 1'b1;
        start = 1'b0;
        din   = 8'h00;
        sel   = 0;
        test_reset();
        test_shift_msb();
        test_shift_lsb();
        test_clkdiv1();
        test_ignore_start();
        test_reset_abort();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
